// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the handshaked sequential ALU.
//   OPW          : op-code width
//   OP_ADD..OP_MUL: op-code values (11-15 are illegal)
//   state_t      : controller states IDLE / BUSY / DONE
//   op_is_legal  : helper that classifies an op code for a given build
package alu_pkg;

  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(5);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(6);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(7);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(8);
  localparam logic [OPW-1:0] OP_SRA  = OPW'(9);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(10);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Single-cycle ops are 0..9; MUL is legal only when the multiplier is built.
  function automatic logic op_is_legal(input logic [OPW-1:0] op, input logic mul_en);
    logic legal;
    legal = (op <= OP_SRA) || (mul_en && (op == OP_MUL));
    return legal;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle for alu_seq.
//   Request side : in_valid, in_ready, a, b, op
//   Response side: out_valid, out_ready, f, ovf, zero, err
//   Modports     : slave (the ALU), master (the producer/consumer around it)
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OPW-1:0]   op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             ovf;
  logic             zero;
  logic             err;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, f, ovf, zero, err
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, f, ovf, zero, err
  );

endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one partial product per cycle.
// Present only when ALU_SEQ_MUL_EN is defined.
//   clk, rst_n    : clock, synchronous active-low reset
//   i_start       : latch operands and begin (pulse)
//   i_a, i_b      : multiplicand, multiplier
//   o_done_c      : high during the final step (combinational)
//   o_prod_lo_c   : low half of the product, valid with o_done_c
//   o_ovf_c       : high half of the product is non-zero, valid with o_done_c
`ifdef ALU_SEQ_MUL_EN
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done_c,
  output logic [WIDTH-1:0] o_prod_lo_c,
  output logic             o_ovf_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic             w_last;

  // {hi,lo} starts as {0,multiplier}; each step conditionally adds the
  // multiplicand into hi and shifts the whole pair right by one.
  always_comb begin
    w_addend = r_lo[0] ? r_mcand : '0;
    w_sum    = {1'b0, r_hi} + {1'b0, w_addend};
    w_hi_nxt = w_sum[WIDTH:1];
    w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    w_last   = r_busy && (r_cnt == CW'(WIDTH - 1));
  end

  // Expose the final step's result combinationally so the caller can
  // register it on the same edge the last step completes.
  assign o_done_c    = w_last;
  assign o_prod_lo_c = w_lo_nxt;
  assign o_ovf_c     = |w_hi_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (i_start) begin
      r_mcand <= i_a;
      r_hi    <= '0;
      r_lo    <= i_b;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU for the multi-cycle CPU datapath.
// Optional iterative multiplier (op 10) enabled by defining ALU_SEQ_MUL_EN;
// without it op 10 is reported as illegal and no BUSY state is reachable.
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_seq_if.slave -- in_valid/in_ready/a/b/op request,
//           out_valid/out_ready/f/ovf/zero/err response
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t r_state;
  state_t w_state_nxt;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_f;
  logic             r_ovf;
  logic             r_zero;
  logic             r_err;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_load_alu;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_res_ovf;
  logic             w_res_err;

`ifdef ALU_SEQ_MUL_EN
  logic             w_load_mul;
  logic             w_mul_start;
  logic             w_mul_done_c;
  logic [WIDTH-1:0] w_mul_f_c;
  logic             w_mul_ovf_c;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_mul_start),
    .i_a         (bus.a),
    .i_b         (bus.b),
    .o_done_c    (w_mul_done_c),
    .o_prod_lo_c (w_mul_f_c),
    .o_ovf_c     (w_mul_ovf_c)
  );
`endif

  // A consumer taking the current result frees the slot in the same cycle.
  assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.f         = r_f;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
  assign bus.err       = r_err;

  // Single-cycle datapath, evaluated on the presented operands.
  always_comb begin
    w_shamt   = bus.b[SHW-1:0];
    w_sum     = bus.a + bus.b;
    w_diff    = bus.a - bus.b;
    w_res     = '0;
    w_res_ovf = 1'b0;
    w_res_err = 1'b0;
    case (bus.op)
      OP_ADD: begin
        w_res     = w_sum;
        w_res_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res     = w_diff;
        w_res_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  w_res = bus.a & bus.b;
      OP_OR:   w_res = bus.a | bus.b;
      OP_XOR:  w_res = bus.a ^ bus.b;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_SLL:  w_res = bus.a << w_shamt;
      OP_SRL:  w_res = bus.a >> w_shamt;
      OP_SRA:  w_res = WIDTH'($signed(bus.a) >>> w_shamt);
      default: w_res_err = !op_is_legal(bus.op,
`ifdef ALU_SEQ_MUL_EN
                                        1'b1
`else
                                        1'b0
`endif
                                        );
    endcase
  end

  // Controller: next state and load strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load_alu  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    w_load_mul  = 1'b0;
    w_mul_start = 1'b0;
`endif
    case (r_state)
      IDLE: w_state_nxt = IDLE;
`ifdef ALU_SEQ_MUL_EN
      BUSY: begin
        if (w_mul_done_c) begin
          w_load_mul  = 1'b1;
          w_state_nxt = DONE;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Accepting from IDLE or back-to-back from DONE is handled identically.
    if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
      if (bus.op == OP_MUL) begin
        w_mul_start = 1'b1;
        w_state_nxt = BUSY;
      end else
`endif
      begin
        w_load_alu  = 1'b1;
        w_state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Result registers only load on completion, so they hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_f         <= '0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == DONE);
      if (w_load_alu) begin
        r_f    <= w_res;
        r_ovf  <= w_res_ovf;
        r_zero <= (w_res == '0);
        r_err  <= w_res_err;
      end
`ifdef ALU_SEQ_MUL_EN
      else if (w_load_mul) begin
        r_f    <= w_mul_f_c;
        r_ovf  <= w_mul_ovf_c;
        r_zero <= (w_mul_f_c == '0);
        r_err  <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq. Expected responses are queued on
// accept and checked by an independent monitor whenever a result is presented.
// Honours ALU_SEQ_MUL_EN the same way as the design.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] f;
    logic         ovf;
    logic         zero;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic exp_t mk(input logic [W-1:0] f, input logic ovf, input logic zero,
                              input logic err, input int lat);
    exp_t e;
    e.f = f; e.ovf = ovf; e.zero = zero; e.err = err; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // Reference model: 64-bit integer arithmetic, overflow by range test.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint          sa, sb_, r;
    longint unsigned ua, ub, p;
    int              sh;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(b[4:0]);
    e = mk('0, 1'b0, 1'b0, 1'b0, 1);
    case (op)
      OP_ADD: begin r = sa + sb_; e.f = r[31:0]; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      OP_SUB: begin r = sa - sb_; e.f = r[31:0]; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      OP_AND:  e.f = a & b;
      OP_OR:   e.f = a | b;
      OP_XOR:  e.f = a ^ b;
      OP_SLT:  e.f = (sa < sb_) ? 32'd1 : 32'd0;
      OP_SLTU: e.f = (ua < ub) ? 32'd1 : 32'd0;
      OP_SLL:  begin p = ua << sh; e.f = p[31:0]; end
      OP_SRL:  begin p = ua >> sh; e.f = p[31:0]; end
      OP_SRA:  begin r = sa >>> sh; e.f = r[31:0]; end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  begin p = ua * ub; e.f = p[31:0]; e.ovf = (p[63:32] != 32'd0); e.lat = 33; end
`endif
      default: e.err = 1'b1;
    endcase
    e.zero = (e.f == '0);
    return e;
  endfunction

  // Present one op, wait (bounded) for accept, queue its expected response.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input exp_t e, input bit rnd_rdy, output int acc_cyc);
    int n;
    bit got;
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    n = 0; got = 1'b0; acc_cyc = -1;
    while (!got && n < 200) begin
      if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.in_ready) begin
        e.acc = cyc;
        sb.push_back(e);
        acc_cyc = cyc;
        got = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: actual=no accept required=accept op=%0d", op);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input bit rnd_rdy);
    repeat (n) begin
      if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", W'(sb.size()), '0);
  endtask

  // Monitor: every presented result is checked against the queue head.
  task automatic monitor();
    bit   fresh;
    exp_t h;
    fresh = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fresh = 1'b1;
      end else if (bus.out_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: actual=f %h required=no output", bus.f);
        end else begin
          h = sb[0];
          if (fresh) begin
            chk("latency", W'(cyc - h.acc), W'(h.lat));
            fresh = 1'b0;
          end
          chk("f", bus.f, h.f);
          chk("ovf", W'(bus.ovf), W'(h.ovf));
          chk("zero", W'(bus.zero), W'(h.zero));
          chk("err", W'(bus.err), W'(h.err));
          if (bus.out_ready) begin
            void'(sb.pop_front());
            fresh = 1'b1;
          end else begin
            chk("in_ready_stall", W'(bus.in_ready), '0);
          end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          c0, c1, c2, c3;
    logic [3:0]  op;
    logic [W-1:0] ra, rb;
    bit          seen;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b0;
    fork monitor(); join_none

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", W'(bus.out_valid), '0);
    chk("rst_f", bus.f, '0);
    chk("rst_ovf", W'(bus.ovf), '0);
    chk("rst_zero", W'(bus.zero), '0);
    chk("rst_err", W'(bus.err), '0);
    chk("rst_in_ready", W'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Signed overflow on ADD
    bus.out_ready = 1'b1;
    send(OP_ADD, 32'h7FFF_FFFF, 32'd1, mk(32'h8000_0000, 1'b1, 1'b0, 1'b0, 1), 1'b0, c0);
    idle(2, 1'b0);

    // SUB to zero, then back-to-back SLT / SLTU
    send(OP_SUB, 32'd5, 32'd5, mk(32'd0, 1'b0, 1'b1, 1'b0, 1), 1'b0, c1);
    send(OP_SLT, 32'hFFFF_FFFF, 32'd1, mk(32'd1, 1'b0, 1'b0, 1'b0, 1), 1'b0, c2);
    chk("b2b_slt", W'(c2 - c1), 32'd1);
    send(OP_SLTU, 32'hFFFF_FFFF, 32'd1, mk(32'd0, 1'b0, 1'b1, 1'b0, 1), 1'b0, c3);
    chk("b2b_sltu", W'(c3 - c2), 32'd1);

    // Shift amount taken from b[4:0] only
    send(OP_SRA, 32'h8000_0000, 32'h0000_0024, mk(32'hF800_0000, 1'b0, 1'b0, 1'b0, 1), 1'b0, c0);
    send(OP_SRL, 32'h8000_0000, 32'h0000_0024, mk(32'h0800_0000, 1'b0, 1'b0, 1'b0, 1), 1'b0, c0);
    idle(2, 1'b0);

    // Backpressure: result must hold for 5 cycles, then out_valid drops
    bus.out_ready = 1'b0;
    send(OP_XOR, 32'h0F0F_0F0F, 32'hFF00_FF00, mk(32'hF00F_F00F, 1'b0, 1'b0, 1'b0, 1), 1'b0, c0);
    idle(5, 1'b0);
    @(negedge clk);
    chk("held_out_valid", W'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("drop_out_valid", W'(bus.out_valid), '0);
    @(posedge clk); #1;

    // Illegal op codes
    send(4'hC, 32'h1234_5678, 32'h9ABC_DEF0, mk(32'd0, 1'b0, 1'b1, 1'b1, 1), 1'b0, c0);
`ifndef ALU_SEQ_MUL_EN
    send(OP_MUL, 32'd3, 32'd5, mk(32'd0, 1'b0, 1'b1, 1'b1, 1), 1'b0, c0);
`endif
    drain();

`ifdef ALU_SEQ_MUL_EN
    // MUL with non-zero high half, then a MUL aborted by reset
    send(OP_MUL, 32'h0001_0000, 32'h0001_0000, mk(32'd0, 1'b1, 1'b1, 1'b0, 33), 1'b0, c0);
    drain();
    send(OP_MUL, 32'h0000_1234, 32'h0000_5678, model(OP_MUL, 32'h0000_1234, 32'h0000_5678), 1'b0, c0);
    idle(9, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_result", W'(seen), '0);
    chk("abort_in_ready", W'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
`endif

    // Randomised traffic with random backpressure
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(11, 15));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'h7FFF_FFFF;
        2: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      send(op, ra, rb, model(op, ra, rb), 1'b1, c0);
      idle($urandom_range(0, 2), 1'b1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
